fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controller for the 16-bit program counter register; decides each cycle whether the PC advances and to which address.
- Drives the PC load-enable and next-address inputs.
- Sequences: reset vector, sequential fetch, pipeline stalls, branch/jump redirects, and instruction-cache miss refill via a req/ack handshake.
- Sits between the PC register, the instruction cache and the branch/jump resolution logic.

Parameters:
- ADDR_W, 16: address width.
- RESET_ADDR, 16'h0000: first fetch address after reset.
- MAX_WAIT, 64: cycles refillReq may stay unacknowledged before fetch error.

Ports:
- clk in 1: clock; all sequential updates on falling edge, same as the PC register.
- rst_n in 1: asynchronous active-low reset.
- instAddr in ADDR_W: current PC value (PC register output).
- cacheHit in 1: icache hit for instAddr, valid every cycle.
- stall in 1: pipeline hazard stall request.
- branchTaken in 1: branch resolved taken this cycle.
- branchTarget in ADDR_W: branch destination.
- jumpValid in 1: jump decoded this cycle.
- jumpTarget in ADDR_W: jump destination.
- refillAck in 1: memory has completed the line refill; 1-cycle pulse.
- nextInstAddr out ADDR_W: PC next value (combinational).
- pcEn out 1: PC load enable, drives PC hit/enable input (combinational).
- refillReq out 1: refill request (registered).
- refillAddr out ADDR_W: miss address (registered, stable while refillReq=1).
- fetchValid out 1: instruction at instAddr is valid this cycle (combinational).
- fetchErr out 1: sticky refill-timeout error (registered).
- missCount out 16: saturating icache miss counter (registered).

Behaviour:
States: RST_VEC, RUN, MISS, RETRY, ERROR.

Reset (rst_n=0, immediate, any state):
- state=RST_VEC; refillReq=0, refillAddr=0, fetchErr=0, missCount=0.
- Wait counter=0, pending redirect cleared.

RST_VEC:
- pcEn=1, nextInstAddr=RESET_ADDR, fetchValid=0.
- Next state RUN (exactly one cycle, inputs ignored).

RUN, priority order:
1. branchTaken: pcEn=1, nextInstAddr=branchTarget. Overrides stall and miss.
2. jumpValid: pcEn=1, nextInstAddr=jumpTarget.
3. stall: pcEn=0.
4. !cacheHit: pcEn=0, fetchValid=0.
   - refillReq<=1, refillAddr<=instAddr, missCount+=1 (saturates at 16'hFFFF).
   - Next state MISS.
5. Otherwise: pcEn=1, nextInstAddr=instAddr+1, modulo 2^ADDR_W (16'hFFFF -> 16'h0000).
- fetchValid = cacheHit & !stall & !branchTaken & !jumpValid.

MISS:
- pcEn=0, fetchValid=0; refillReq held at 1; wait counter increments each cycle.
- branchTaken/jumpValid captured into the pending register (branch wins if both). The latest redirect overwrites any earlier one.
- The refill is never aborted.
- refillAck=1: refillReq<=0, wait counter cleared, next state RETRY.
- Wait counter reaches MAX_WAIT with no ack: refillReq<=0, fetchErr<=1, next state ERROR.
- Ack and MAX_WAIT in the same cycle: ack wins.

RETRY (one cycle):
- Pending redirect present: pcEn=1, nextInstAddr=pending target, pending cleared, next state RUN.
- A live branchTaken/jumpValid this cycle takes precedence over the pending target.
- No redirect: pcEn=0, next state RUN; the lookup is re-evaluated in RUN.

ERROR:
- pcEn=0, fetchValid=0, refillReq=0; fetchErr=1.
- Held until rst_n asserted.

Other rules:
- stall has no effect outside RUN.
- cacheHit is ignored in RST_VEC, MISS and ERROR.

Test Plan:
1. Reset release -> first cycle pcEn=1, nextInstAddr=0000. Then with cacheHit=1 for 4 cycles -> instAddr sequence 0000,0001,0002,0003,0004; fetchValid=1 each cycle.
2. instAddr=0x0010, cacheHit=0 -> refillReq=1, refillAddr=0x0010, missCount=1, pcEn=0 for 3 cycles. Then refillAck pulse -> refillReq=0, RETRY, RUN, PC advances to 0x0011 once hit.
3. stall=1 together with branchTaken=1, branchTarget=0x0200 -> pcEn=1, nextInstAddr=0x0200. stall alone -> pcEn=0, PC unchanged.
4. During MISS: jumpValid with jumpTarget=0x0040, then branchTaken with branchTarget=0x0080. Then refillAck -> in RETRY, nextInstAddr=0x0080, pcEn=1.
5. instAddr=0xFFFF with hit -> nextInstAddr=0x0000. Miss with no ack for 64 cycles -> fetchErr=1, refillReq=0, pcEn stuck 0 until rst_n.
6. rst_n low while in MISS with refillReq=1 -> refillReq=0 and missCount=0 immediately (no clock edge needed). After release -> nextInstAddr=RESET_ADDR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: decides each cycle whether the program counter loads and
// which address it loads. Handles the reset vector, sequential fetch, stalls,
// branch/jump redirects and icache-miss refill through a req/ack handshake.
// State updates on the falling clock edge, in step with the PC register.
module fetch_sequencer #(
    parameter int              ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int              MAX_WAIT   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] instAddr,
    input  logic              cacheHit,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              jumpValid,
    input  logic [ADDR_W-1:0] jumpTarget,
    input  logic              refillAck,
    output logic [ADDR_W-1:0] nextInstAddr,
    output logic              pcEn,
    output logic              refillReq,
    output logic [ADDR_W-1:0] refillAddr,
    output logic              fetchValid,
    output logic              fetchErr,
    output logic [15:0]       missCount
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        RST_VEC = 3'd0,
        RUN     = 3'd1,
        MISS    = 3'd2,
        RETRY   = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic              refill_req_reg;
    logic [ADDR_W-1:0] refill_addr_reg;
    logic              fetch_err_reg;
    logic [15:0]       miss_count_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              pend_valid_reg;
    logic [ADDR_W-1:0] pend_addr_reg;

    // A miss is only taken when no redirect or stall outranks it
    logic miss_start;
    assign miss_start = (state_reg == RUN) && !branchTaken && !jumpValid
                        && !stall && !cacheHit;

    logic wait_expired;
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);

    // State register
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= RST_VEC;
        else        state_reg <= state_next;
    end

    // Next-state decode; an ack arriving on the last wait cycle still wins
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RST_VEC: state_next = RUN;
            RUN:     if (miss_start) state_next = MISS;
            MISS: begin
                if (refillAck)         state_next = RETRY;
                else if (wait_expired) state_next = ERROR;
            end
            RETRY:   state_next = RUN;
            ERROR:   state_next = ERROR;
            default: state_next = RST_VEC;
        endcase
    end

    // Refill handshake, timeout, miss counter and pending-redirect registers
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill_req_reg  <= 1'b0;
            refill_addr_reg <= '0;
            fetch_err_reg   <= 1'b0;
            miss_count_reg  <= '0;
            wait_cnt_reg    <= '0;
            pend_valid_reg  <= 1'b0;
            pend_addr_reg   <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (miss_start) begin
                        refill_req_reg  <= 1'b1;
                        refill_addr_reg <= instAddr;
                        wait_cnt_reg    <= '0;
                        pend_valid_reg  <= 1'b0;
                        if (miss_count_reg != 16'hFFFF)
                            miss_count_reg <= miss_count_reg + 16'd1;
                    end
                end
                MISS: begin
                    // Latest redirect seen during the refill replaces older ones
                    if (branchTaken) begin
                        pend_valid_reg <= 1'b1;
                        pend_addr_reg  <= branchTarget;
                    end else if (jumpValid) begin
                        pend_valid_reg <= 1'b1;
                        pend_addr_reg  <= jumpTarget;
                    end
                    if (refillAck) begin
                        refill_req_reg <= 1'b0;
                        wait_cnt_reg   <= '0;
                    end else if (wait_expired) begin
                        refill_req_reg <= 1'b0;
                        fetch_err_reg  <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                RETRY: pend_valid_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    // PC control outputs; a live redirect in RETRY outranks the pending one
    always_comb begin
        pcEn         = 1'b0;
        nextInstAddr = instAddr;
        fetchValid   = 1'b0;
        case (state_reg)
            RST_VEC: begin
                pcEn         = 1'b1;
                nextInstAddr = RESET_ADDR;
            end
            RUN: begin
                fetchValid = cacheHit & !stall & !branchTaken & !jumpValid;
                if (branchTaken) begin
                    pcEn         = 1'b1;
                    nextInstAddr = branchTarget;
                end else if (jumpValid) begin
                    pcEn         = 1'b1;
                    nextInstAddr = jumpTarget;
                end else if (!stall && cacheHit) begin
                    pcEn         = 1'b1;
                    nextInstAddr = instAddr + ADDR_W'(1);
                end
            end
            RETRY: begin
                if (branchTaken) begin
                    pcEn         = 1'b1;
                    nextInstAddr = branchTarget;
                end else if (jumpValid) begin
                    pcEn         = 1'b1;
                    nextInstAddr = jumpTarget;
                end else if (pend_valid_reg) begin
                    pcEn         = 1'b1;
                    nextInstAddr = pend_addr_reg;
                end
            end
            default: ;
        endcase
    end

    assign refillReq  = refill_req_reg;
    assign refillAddr = refill_addr_reg;
    assign fetchErr   = fetch_err_reg;
    assign missCount  = miss_count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small PC register model that
// loads on the falling edge whenever pcEn is high.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] instAddr;
    logic        cacheHit;
    logic        stall;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic        jumpValid;
    logic [15:0] jumpTarget;
    logic        refillAck;
    logic [15:0] nextInstAddr;
    logic        pcEn;
    logic        refillReq;
    logic [15:0] refillAddr;
    logic        fetchValid;
    logic        fetchErr;
    logic [15:0] missCount;

    int n_checks = 0;
    int n_errors = 0;

    fetch_sequencer #(.ADDR_W(16), .RESET_ADDR(16'h0000), .MAX_WAIT(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instAddr     (instAddr),
        .cacheHit     (cacheHit),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .jumpValid    (jumpValid),
        .jumpTarget   (jumpTarget),
        .refillAck    (refillAck),
        .nextInstAddr (nextInstAddr),
        .pcEn         (pcEn),
        .refillReq    (refillReq),
        .refillAddr   (refillAddr),
        .fetchValid   (fetchValid),
        .fetchErr     (fetchErr),
        .missCount    (missCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: powers up to a junk value so the reset vector load is visible
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n)    instAddr <= 16'hBEEF;
        else if (pcEn) instAddr <= nextInstAddr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end else begin
            $display("ok   %s got %h", tag, got);
        end
    endtask

    // Step past the next falling edge and let registered values settle
    task automatic adv();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cacheHit = 1'b1; stall = 1'b0;
        branchTaken = 1'b0; branchTarget = '0;
        jumpValid = 1'b0; jumpTarget = '0; refillAck = 1'b0;

        // Reset and sequential fetch
        repeat (3) @(negedge clk);
        #2;
        chk("rst_refillReq", 32'(refillReq), 32'h0);
        chk("rst_fetchErr",  32'(fetchErr),  32'h0);
        chk("rst_missCount", 32'(missCount), 32'h0);
        rst_n = 1'b1;
        #2;
        chk("rv_pcEn",       32'(pcEn),         32'h1);
        chk("rv_next",       32'(nextInstAddr), 32'h0000);
        chk("rv_fetchValid", 32'(fetchValid),   32'h0);
        adv();
        chk("rv_pc", 32'(instAddr), 32'h0000);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("seq_fetchValid", 32'(fetchValid),   32'h1);
            chk("seq_next",       32'(nextInstAddr), 32'(i + 1));
            adv();
            chk("seq_pc", 32'(instAddr), 32'(i + 1));
        end

        // Branch overrides stall; stall alone holds the PC
        branchTaken = 1'b1; stall = 1'b1; branchTarget = 16'h0200;
        #2;
        chk("br_stall_pcEn",   32'(pcEn),         32'h1);
        chk("br_stall_next",   32'(nextInstAddr), 32'h0200);
        chk("br_stall_fvalid", 32'(fetchValid),   32'h0);
        adv();
        chk("br_pc", 32'(instAddr), 32'h0200);
        branchTaken = 1'b0;
        #2;
        chk("stall_pcEn", 32'(pcEn), 32'h0);
        adv();
        chk("stall_pc", 32'(instAddr), 32'h0200);
        stall = 1'b0;

        // Miss at 0x0010, refill, retry, resume
        jumpValid = 1'b1; jumpTarget = 16'h0010;
        #2;
        chk("jmp_next", 32'(nextInstAddr), 32'h0010);
        adv();
        jumpValid = 1'b0;
        chk("jmp_pc", 32'(instAddr), 32'h0010);
        cacheHit = 1'b0;
        #2;
        chk("miss_pcEn",   32'(pcEn),       32'h0);
        chk("miss_fvalid", 32'(fetchValid), 32'h0);
        adv();
        chk("miss_req",   32'(refillReq),  32'h1);
        chk("miss_addr",  32'(refillAddr), 32'h0010);
        chk("miss_count", 32'(missCount),  32'h1);
        cacheHit = 1'b1;
        repeat (2) begin
            #2;
            chk("miss_hold_pcEn", 32'(pcEn), 32'h0);
            adv();
            chk("miss_hold_req", 32'(refillReq), 32'h1);
        end
        refillAck = 1'b1;
        #2;
        chk("ack_pcEn", 32'(pcEn), 32'h0);
        adv();
        refillAck = 1'b0;
        chk("ack_req", 32'(refillReq), 32'h0);
        #2;
        chk("retry_pcEn", 32'(pcEn), 32'h0);
        adv();
        chk("retry_pc", 32'(instAddr), 32'h0010);
        #2;
        chk("resume_pcEn", 32'(pcEn),         32'h1);
        chk("resume_next", 32'(nextInstAddr), 32'h0011);
        adv();
        chk("resume_pc", 32'(instAddr), 32'h0011);

        // Redirects during a miss: latest (branch 0x0080) wins in RETRY
        cacheHit = 1'b0;
        adv();
        chk("miss2_count", 32'(missCount),  32'h2);
        chk("miss2_addr",  32'(refillAddr), 32'h0011);
        cacheHit = 1'b1;
        jumpValid = 1'b1; jumpTarget = 16'h0040;
        #2;
        chk("miss2_jmp_pcEn", 32'(pcEn), 32'h0);
        adv();
        jumpValid = 1'b0;
        branchTaken = 1'b1; branchTarget = 16'h0080;
        adv();
        branchTaken = 1'b0;
        adv();
        refillAck = 1'b1;
        adv();
        refillAck = 1'b0;
        #2;
        chk("pend_pcEn", 32'(pcEn),         32'h1);
        chk("pend_next", 32'(nextInstAddr), 32'h0080);
        adv();
        chk("pend_pc", 32'(instAddr), 32'h0080);

        // Wrap at 0xFFFF, then refill timeout into ERROR
        branchTaken = 1'b1; branchTarget = 16'hFFFF;
        adv();
        branchTaken = 1'b0;
        chk("wrap_pc_ffff", 32'(instAddr), 32'hFFFF);
        #2;
        chk("wrap_next", 32'(nextInstAddr), 32'h0000);
        adv();
        chk("wrap_pc", 32'(instAddr), 32'h0000);
        cacheHit = 1'b0;
        adv();
        chk("to_count", 32'(missCount), 32'h3);
        repeat (63) adv();
        chk("to_pre_err", 32'(fetchErr),  32'h0);
        chk("to_pre_req", 32'(refillReq), 32'h1);
        adv();
        chk("to_err", 32'(fetchErr),  32'h1);
        chk("to_req", 32'(refillReq), 32'h0);
        branchTaken = 1'b1; cacheHit = 1'b1;
        #2;
        chk("err_pcEn",   32'(pcEn),       32'h0);
        chk("err_fvalid", 32'(fetchValid), 32'h0);
        repeat (3) adv();
        chk("err_hold_pcEn", 32'(pcEn),     32'h0);
        chk("err_hold_err",  32'(fetchErr), 32'h1);
        branchTaken = 1'b0;

        // Asynchronous reset while a refill is outstanding
        rst_n = 1'b0;
        #2;
        chk("rst2_err", 32'(fetchErr), 32'h0);
        rst_n = 1'b1;
        adv();
        chk("rst2_pc", 32'(instAddr), 32'h0000);
        cacheHit = 1'b0;
        adv();
        chk("miss3_req",   32'(refillReq), 32'h1);
        chk("miss3_count", 32'(missCount), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(refillReq),    32'h0);
        chk("arst_count", 32'(missCount),    32'h0);
        chk("arst_pcEn",  32'(pcEn),         32'h1);
        chk("arst_next",  32'(nextInstAddr), 32'h0000);
        adv();
        rst_n = 1'b1;
        cacheHit = 1'b1;
        #2;
        chk("rel_next", 32'(nextInstAddr), 32'h0000);
        adv();
        chk("rel_pc", 32'(instAddr), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
